// File: rtl/ram_disp_seq.sv
// Plays RAM entries 0..num_entries-1 onto a 4-digit 7-segment display: {addr hex, hundreds, tens, units}.
// Latency: 1 fetch + 1 latch + 8 convert cycles per entry, then DWELL_CYCLES of display; no backpressure, start ignored while busy.
// Optional DISP_LOOP_EN: wrap back to entry 0 after the last SHOW instead of stopping in DONE.
module ram_disp_seq #(
   parameter int DWELL_CYCLES   = 100000000,
   parameter int REFRESH_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [3:0] num_entries,
   input  logic [7:0] ram_data,
   output logic [3:0] ram_addr,
   output logic [3:0] anodes,
   output logic [7:0] segments,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, CONVERT, SHOW, DONE} state_t;

   state_t      state, state_nx;
   logic [3:0]  num_lat;
   logic [19:0] conv_sr, conv_adj, conv_nx;
   logic [2:0]  cvt_cnt;
   logic [3:0]  dig3, dig2, dig1, dig0, dig_sel;
   logic [31:0] dwell_cnt, ref_cnt;
   logic [1:0]  scan_idx;
   logic        dwell_last, ref_last, more_entries;

   assign dwell_last   = (dwell_cnt == 32'(DWELL_CYCLES - 1));
   assign ref_last     = (ref_cnt == 32'(REFRESH_CYCLES - 1));
   assign more_entries = ((5'(ram_addr) + 5'd1) < 5'(num_lat));
   assign busy         = (state != IDLE) && (state != DONE);
   assign done         = (state == DONE);

   function automatic logic [7:0] seg_enc(input logic [3:0] d);
      case (d)
         4'h0: seg_enc = 8'h03;  4'h1: seg_enc = 8'h9F;
         4'h2: seg_enc = 8'h25;  4'h3: seg_enc = 8'h0D;
         4'h4: seg_enc = 8'h99;  4'h5: seg_enc = 8'h49;
         4'h6: seg_enc = 8'h41;  4'h7: seg_enc = 8'h1F;
         4'h8: seg_enc = 8'h01;  4'h9: seg_enc = 8'h09;
         4'hA: seg_enc = 8'h11;  4'hB: seg_enc = 8'hC1;
         4'hC: seg_enc = 8'h63;  4'hD: seg_enc = 8'h85;
         4'hE: seg_enc = 8'h61;  default: seg_enc = 8'h71;
      endcase
   endfunction

   // Shift-add-3 step: [19:16] hundreds, [15:12] tens, [11:8] units, [7:0] binary value.
   // Hundreds never exceeds 2, so the bit rotated back into [0] is always zero.
   always_comb begin
      conv_adj = conv_sr;
      if (conv_sr[11:8]  >= 4'd5) conv_adj[11:8]  = conv_sr[11:8]  + 4'd3;
      if (conv_sr[15:12] >= 4'd5) conv_adj[15:12] = conv_sr[15:12] + 4'd3;
      if (conv_sr[19:16] >= 4'd5) conv_adj[19:16] = conv_sr[19:16] + 4'd3;
      conv_nx = {conv_adj[18:0], conv_adj[19]};
   end

   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: if (start) state_nx = (num_entries == 4'd0) ? DONE : FETCH;
         FETCH:      state_nx = LATCH;
         LATCH:      state_nx = CONVERT;
         CONVERT:    if (cvt_cnt == 3'd7) state_nx = SHOW;
         SHOW: begin
            if (dwell_last) begin
               if (more_entries) state_nx = FETCH;
               else begin
`ifdef DISP_LOOP_EN
                  state_nx = FETCH;
`else
                  state_nx = DONE;
`endif
               end
            end
         end
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         num_lat   <= 4'd0;
         ram_addr  <= 4'd0;
         conv_sr   <= 20'd0;
         cvt_cnt   <= 3'd0;
         dig3      <= 4'd0;
         dig2      <= 4'd0;
         dig1      <= 4'd0;
         dig0      <= 4'd0;
         dwell_cnt <= 32'd0;
         ref_cnt   <= 32'd0;
         scan_idx  <= 2'd0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start && (num_entries != 4'd0)) begin
                  num_lat  <= num_entries;
                  ram_addr <= 4'd0;
               end
            end
            LATCH: begin
               conv_sr <= {12'd0, ram_data};
               cvt_cnt <= 3'd0;
            end
            CONVERT: begin
               conv_sr <= conv_nx;
               cvt_cnt <= cvt_cnt + 3'd1;
               if (cvt_cnt == 3'd7) begin
                  dig3 <= ram_addr;
                  dig2 <= conv_nx[19:16];
                  dig1 <= conv_nx[15:12];
                  dig0 <= conv_nx[11:8];
               end
            end
            SHOW: begin
               if (dwell_last) begin
                  dwell_cnt <= 32'd0;
                  if (more_entries) ram_addr <= ram_addr + 4'd1;
`ifdef DISP_LOOP_EN
                  else              ram_addr <= 4'd0;
`endif
               end else begin
                  dwell_cnt <= dwell_cnt + 32'd1;
               end
            end
            default: ;
         endcase

         // Scanner is parked at digit 0 while idle so playback always starts on the rightmost digit.
         if (state == IDLE) begin
            ref_cnt  <= 32'd0;
            scan_idx <= 2'd0;
         end else if (ref_last) begin
            ref_cnt  <= 32'd0;
            scan_idx <= scan_idx + 2'd1;
         end else begin
            ref_cnt  <= ref_cnt + 32'd1;
         end
      end
   end

   always_comb begin
      case (scan_idx)
         2'd0:    dig_sel = dig0;
         2'd1:    dig_sel = dig1;
         2'd2:    dig_sel = dig2;
         default: dig_sel = dig3;
      endcase
      anodes   = 4'b1111;
      segments = 8'hFF;
      if (state != IDLE) begin
         anodes   = ~(4'b0001 << scan_idx);
         segments = seg_enc(dig_sel);
      end
   end

endmodule
